store_rmw_unit: RTL and testbench

// - Store path of the CPU data-memory interface: the write-side counterpart of the load sign/zero-extension logic.
// - Takes sb/sh/sw requests from the MEM stage and writes them into a single-port, word-wide, synchronous-read data RAM.
// - A word store is a direct write. A byte or halfword store is a read-modify-write that merges the new lanes into the old word.
// - Holds the pipeline through st_ready while busy. Flags misaligned stores.

---
 rtl/cpu_mem_pkg.sv | 31 +++
 rtl/store_lane_merge.sv | 38 +++
 rtl/store_rmw_unit.sv | 120 ++++++++++++
 tb/tb_store_rmw_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory interface.
//   - store-size codes driven by the MEM stage
//   - state encoding of the store read-modify-write FSM
//   - is_misaligned(): alignment rule for a store of a given size
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_MRG  = 3'd3,
    S_ERR  = 3'd4
  } store_state_t;

  // The reserved size code 2'b11 follows the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge for sub-word stores (little-endian).
// Ports:
//   old_word [31:0]  word currently held in memory
//   new_data [31:0]  right-justified store data
//   size     [1:0]   store-size code (byte / half / word-or-reserved)
//   lo       [1:0]   byte address bits [1:0]
//   merged   [31:0]  old_word with the addressed lane(s) replaced
module store_lane_merge
  import cpu_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (lo)
          2'd0:    merged[7:0]   = new_data[7:0];
          2'd1:    merged[15:8]  = new_data[7:0];
          2'd2:    merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        // Only lo[1] selects the half; lo[0] is an alignment concern.
        if (lo[1]) merged[31:16] = new_data[15:0];
        else       merged[15:0]  = new_data[15:0];
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store path of the data-memory interface.
// Word stores write directly; byte/half stores read the old word, merge the
// new lane(s) and write the word back. Misaligned stores retire with st_err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   st_valid/st_ready        request handshake: a request transfers in any
//                            cycle where both are 1; st_ready is 1 only when
//                            idle and all inputs are ignored otherwise
//   st_size/st_addr/st_data  request fields, captured on transfer
//   st_done/st_err           1-cycle retire pulse, err = misaligned
//   mem_addr/mem_re/mem_we   single-port synchronous-read RAM control
//   mem_wdata/mem_rdata      RAM write / read data (rdata valid the cycle after re)
module store_rmw_unit
  import cpu_mem_pkg::*;
#(
  parameter int MEM_AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  output logic              st_done,
  output logic              st_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  store_state_t state;
  logic [1:0]   size_q;
  logic [1:0]   lo_q;
  logic [31:0]  data_q;
  logic [31:0]  merged;

  // Address bits above the RAM are intentionally dropped (address wraps).
  logic unused_addr_hi;
  assign unused_addr_hi = ^st_addr[31:MEM_AW+2];

  store_lane_merge u_merge (
    .old_word (mem_rdata),
    .new_data (data_q),
    .size     (size_q),
    .lo       (lo_q),
    .merged   (merged)
  );

  // Control outputs are registered; they take the value belonging to the
  // state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      st_ready <= 1'b1;
      st_done  <= 1'b0;
      st_err   <= 1'b0;
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      size_q   <= SZ_BYTE;
      lo_q     <= 2'b00;
      data_q   <= '0;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (st_valid && st_ready) begin
            size_q   <= st_size;
            lo_q     <= st_addr[1:0];
            data_q   <= st_data;
            st_ready <= 1'b0;
            if (is_misaligned(st_size, st_addr[1:0])) begin
              state   <= S_ERR;
              st_done <= 1'b1;
              st_err  <= 1'b1;
            end else if (st_size == SZ_BYTE || st_size == SZ_HALF) begin
              state    <= S_RD;
              mem_re   <= 1'b1;
              mem_addr <= st_addr[MEM_AW+1:2];
            end else begin
              state    <= S_WR;
              mem_we   <= 1'b1;
              st_done  <= 1'b1;
              mem_addr <= st_addr[MEM_AW+1:2];
            end
          end
        end
        S_RD: begin
          state   <= S_MRG;
          mem_we  <= 1'b1;
          st_done <= 1'b1;
        end
        default: begin
          // WR, MRG and ERR all retire in one cycle and return to idle.
          state    <= S_IDLE;
          st_ready <= 1'b1;
          mem_addr <= '0;
        end
      endcase
    end
  end

  // Merge data comes from the RAM in the MRG cycle itself, so the write
  // data mux cannot be registered.
  always_comb begin
    mem_wdata = '0;
    case (state)
      S_WR:    mem_wdata = data_q;
      S_MRG:   mem_wdata = merged;
      default: mem_wdata = '0;
    endcase
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
module tb_store_rmw_unit;
  localparam int MEM_AW = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              st_valid, st_ready, st_done, st_err;
  logic [1:0]        st_size;
  logic [31:0]       st_addr, st_data;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_re, mem_we;
  logic [31:0]       mem_wdata, mem_rdata;

  store_rmw_unit #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data),
    .st_done(st_done), .st_err(st_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- RAM model ----------------
  logic [31:0] ram [0:(1<<MEM_AW)-1];
  int          wr_cnt  = 0;
  int          act_cnt = 0;
  int          cyc     = 0;
  logic        pre_en = 1'b0;
  logic [MEM_AW-1:0] pre_a;
  logic [31:0] pre_d;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_en) begin
      ram[pre_a] <= pre_d;
    end
    if (mem_re || mem_we) act_cnt <= act_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_b [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    pre_a = a[MEM_AW-1:0]; pre_d = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Presents one request at a negedge; returns at the next negedge (cycle T+1).
  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_size = sz; st_addr = a; st_data = d;
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!st_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) check({tag, "_timeout"}, 32'(st_ready), 32'd1);
  endtask

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a[5:0]);
    if (sz == 2'b00) ref_b[b] = d[7:0];
    else if (sz == 2'b01) begin ref_b[b] = d[7:0]; ref_b[b+1] = d[15:8]; end
    else for (int i = 0; i < 4; i++) ref_b[b+i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int w0, a0, c_sb, c_sw, c_sh;
    logic [1:0]  bq_sz [3];
    logic [31:0] bq_a  [3];
    logic [31:0] bq_d  [3];

    rst = 1'b1; st_valid = 1'b0; st_size = 2'b00; st_addr = '0; st_data = '0;
    for (int i = 0; i < 64; i++) ref_b[i] = 8'h00;
    for (int i = 0; i < (1<<MEM_AW); i++) ram[i] = 32'h0;
    preload(1, 32'h11223344);
    preload(0, 32'h11223344);
    preload(2, 32'h11223344);
    preload(8, 32'hA0A1A2A3);

    @(negedge clk);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_outs", {25'd0, st_done, st_err, mem_re, mem_we, 3'd0}, 32'd0);
    check("rst_addr_wdata", {21'd0, mem_addr} | mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // sb: RAM[1]=11223344, addr 6, data AB
    check("sb_ready_T", 32'(st_ready), 32'd1);
    issue(2'b00, 32'h6, 32'hAB);
    check("sb_re_T1", {st_done, mem_we, mem_re}, 3'b001);
    check("sb_addr_T1", 32'(mem_addr), 32'd1);
    @(negedge clk);
    check("sb_we_done_T2", {st_err, st_done, mem_we, mem_re}, 4'b0110);
    check("sb_wdata", mem_wdata, 32'h11AB3344);
    @(negedge clk);
    check("sb_ready_T3", 32'(st_ready), 32'd1);
    check("sb_ram", ram[1], 32'h11AB3344);

    // sh upper half and lower half
    issue(2'b01, 32'h2, 32'hBEEF);
    @(negedge clk);
    check("sh_hi_wdata", mem_wdata, 32'hBEEF3344);
    @(negedge clk);
    issue(2'b01, 32'h8, 32'hBEEF);
    @(negedge clk);
    check("sh_lo_wdata", mem_wdata, 32'h1122BEEF);
    @(negedge clk);

    // sw: addr 10
    issue(2'b10, 32'h10, 32'hDEADBEEF);
    check("sw_T1_ctrl", {st_err, st_done, mem_we, mem_re, st_ready}, 5'b01100);
    check("sw_T1_addr", 32'(mem_addr), 32'd4);
    check("sw_T1_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("sw_T2_ready", {st_ready, mem_we, st_done}, 3'b100);
    check("sw_ram", ram[4], 32'hDEADBEEF);

    // address wrap: upper bits ignored
    issue(2'b11, 32'h8000_0014, 32'h0BADF00D);
    check("wrap_addr", 32'(mem_addr), 32'd5);
    @(negedge clk);
    check("wrap_ram", ram[5], 32'h0BADF00D);

    // misaligned sw addr 5 and sh addr 3
    a0 = act_cnt;
    issue(2'b10, 32'h5, 32'h12345678);
    check("mis_sw_T1", {st_done, st_err, mem_we, mem_re}, 4'b1100);
    @(negedge clk);
    check("mis_sw_T2", {st_ready, st_done, st_err}, 3'b100);
    issue(2'b01, 32'h3, 32'h5555);
    check("mis_sh_T1", {st_done, st_err, mem_we, mem_re}, 4'b1100);
    @(negedge clk);
    check("mis_sh_T2", {st_ready, st_done, st_err}, 3'b100);
    check("mis_no_mem", 32'(act_cnt - a0), 32'd0);

    // back-to-back: sb, sw, sh with st_valid held high
    for (int i = 0; i < 4; i++) begin
      ref_b[32+i] = 8'(32'hA0A1A2A3 >> (8*i));
      ref_b[36+i] = 8'h00;
    end
    bq_sz[0] = 2'b00; bq_a[0] = 32'h21; bq_d[0] = 32'hFFFFFF5A;
    bq_sz[1] = 2'b10; bq_a[1] = 32'h24; bq_d[1] = 32'hCAFEF00D;
    bq_sz[2] = 2'b01; bq_a[2] = 32'h22; bq_d[2] = 32'hFFFF1234;
    w0 = wr_cnt;
    c_sb = 0; c_sw = 0; c_sh = 0;
    for (int k = 0; k < 3; k++) begin
      st_valid = 1'b1; st_size = bq_sz[k]; st_addr = bq_a[k]; st_data = bq_d[k];
      ref_store(bq_sz[k], bq_a[k], bq_d[k]);
      wait_ready("b2b");
      if (k == 0) c_sb = cyc; else if (k == 1) c_sw = cyc; else c_sh = cyc;
      @(negedge clk);
    end
    st_valid = 1'b0;
    wait_ready("b2b_end");
    @(negedge clk);
    check("b2b_acc_sw", 32'(c_sw - c_sb), 32'd3);
    check("b2b_acc_sh", 32'(c_sh - c_sb), 32'd5);
    check("b2b_writes", 32'(wr_cnt - w0), 32'd3);
    exp_q.push_back(ref_word(8));
    exp_q.push_back(ref_word(9));
    check("b2b_ram8", ram[8], exp_q.pop_front());
    check("b2b_ram9", ram[9], exp_q.pop_front());

    // reset during the RD cycle of an sb
    w0 = wr_cnt;
    issue(2'b00, 32'h6, 32'h77);
    check("rstmid_rd", 32'(mem_re), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_ready", 32'(st_ready), 32'd1);
    check("rstmid_outs", {25'd0, st_done, st_err, mem_re, mem_we, 3'd0}, 32'd0);
    check("rstmid_addr_wdata", {21'd0, mem_addr} | mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_no_write", 32'(wr_cnt - w0), 32'd0);
    check("rstmid_ram", ram[1], 32'h11AB3344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
